// File: rtl/game_pkg.sv
// Shared game definitions: FSM state encoding, colour width and screen geometry.
// No logic; types and constants only.
// Imported by the compositor and its helpers.
package game_pkg;

  // Game state encoding
  typedef enum logic [1:0] {
    RUN       = 2'd0,
    HIT       = 2'd1,
    GAME_OVER = 2'd2
  } state_t;

  // RGB444 colour channel width
  localparam int RGB_W = 4;

  // Active screen size
  localparam int SCREEN_W = 1280;
  localparam int SCREEN_H = 1024;

  // Coordinate widths sized to hold the full timing-generator range
  localparam int COL_W = $clog2(SCREEN_W) + 1;
  localparam int ROW_W = $clog2(SCREEN_H) + 1;

  // One composited pixel
  typedef struct packed {
    logic [RGB_W-1:0] r;
    logic [RGB_W-1:0] g;
    logic [RGB_W-1:0] b;
  } rgb_t;

endpackage

// File: rtl/pipe_delay.sv
// Single-bit shift register of configurable depth with configurable reset value.
// Latency: DEPTH cycles (DEPTH = 0 is a plain wire).
// No backpressure; advances every clock.
module pipe_delay #(
  parameter int   DEPTH   = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic data,
  output logic delayed
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign delayed = data;
    end else begin : g_reg
      logic [DEPTH-1:0] stages;

      // Shift the input through DEPTH flops; stage 0 takes the newest sample
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          stages <= {DEPTH{RST_VAL}};
        end else begin
          stages[0] <= data;
          for (int i = 1; i < DEPTH; i++) begin
            stages[i] <= stages[i-1];
          end
        end
      end

      assign delayed = stages[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/pixel_mixer.sv
// Final compositor: priority layer select, sync alignment, overlap-based collision and lives FSM.
// Latency: colour 1 cycle, syncs SYNC_DELAY+1 cycles, game outputs 2 cycles after col/row 0/0.
// No backpressure; streams one pixel per clock.
module pixel_mixer
  import game_pkg::*;
#(
  parameter int SYNC_DELAY    = 2,
  parameter int HIT_THRESHOLD = 8,
  parameter int LIVES         = 3,
  parameter int FLASH_FRAMES  = 60
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [COL_W-1:0] display_col,
  input  logic [ROW_W-1:0] display_row,
  input  logic             visible,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic [RGB_W-1:0] char_red,
  input  logic [RGB_W-1:0] char_green,
  input  logic [RGB_W-1:0] char_blue,
  input  logic             char_visible,
  input  logic [RGB_W-1:0] obst_red,
  input  logic [RGB_W-1:0] obst_green,
  input  logic [RGB_W-1:0] obst_blue,
  input  logic             obst_visible,
  input  logic [RGB_W-1:0] bg_red,
  input  logic [RGB_W-1:0] bg_green,
  input  logic [RGB_W-1:0] bg_blue,
  input  logic             restart_key,
  output logic [RGB_W-1:0] vga_r,
  output logic [RGB_W-1:0] vga_g,
  output logic [RGB_W-1:0] vga_b,
  output logic             vga_hs,
  output logic             vga_vs,
  output logic             collision,
  output logic             game_over,
  output logic [1:0]       lives_left
);

  localparam int OVL_W   = 12;
  localparam int FLASH_W = 8;

  localparam logic [OVL_W-1:0]   OVL_MAX    = {OVL_W{1'b1}};
  localparam logic [OVL_W-1:0]   HIT_LIMIT  = OVL_W'(HIT_THRESHOLD);
  localparam logic [FLASH_W-1:0] FLASH_LOAD = FLASH_W'(FLASH_FRAMES);
  localparam logic [1:0]         LIVES_LOAD = 2'(LIVES);

  // Timing signals aligned with the sprite pipeline
  logic vis_d;
  logic hs_d;
  logic vs_d;

  pipe_delay #(.DEPTH(SYNC_DELAY), .RST_VAL(1'b0)) u_vis_delay (
    .clock   (clock),
    .reset   (reset),
    .data    (visible),
    .delayed (vis_d)
  );

  pipe_delay #(.DEPTH(SYNC_DELAY), .RST_VAL(1'b1)) u_hs_delay (
    .clock   (clock),
    .reset   (reset),
    .data    (hsync_in),
    .delayed (hs_d)
  );

  pipe_delay #(.DEPTH(SYNC_DELAY), .RST_VAL(1'b1)) u_vs_delay (
    .clock   (clock),
    .reset   (reset),
    .data    (vsync_in),
    .delayed (vs_d)
  );

  // Game state
  state_t               state;
  state_t               state_next;
  logic [1:0]           lives_next;
  logic [FLASH_W-1:0]   flash_cnt;
  logic [FLASH_W-1:0]   flash_next;
  logic                 collision_next;
  logic                 restart;
  logic [OVL_W-1:0]     overlap;
  logic                 overlap_inc;
  logic                 frame_tick;

  // Restart pushbutton synchroniser and rising-edge detector
  logic key_meta;
  logic key_sync;
  logic key_prev;
  logic key_rise;

  // Composited pixel before the output register
  rgb_t pix;
  logic char_en;

  // Frame start marker from undelayed coordinates, registered once
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= (display_col == '0) && (display_row == '0);
    end
  end

  // Two-flop synchroniser plus edge-detect history for the restart button
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      key_meta <= 1'b0;
      key_sync <= 1'b0;
      key_prev <= 1'b0;
    end else begin
      key_meta <= restart_key;
      key_sync <= key_meta;
      key_prev <= key_sync;
    end
  end

  assign key_rise = key_sync && !key_prev;

  // Overlap only counts while the runner is vulnerable and the pixel is on screen
  assign overlap_inc = (state == RUN) && vis_d && char_visible && obst_visible;

  // Per-frame overlap counter; a same-cycle overlap at the tick opens the new frame at 1
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overlap <= '0;
    end else if (restart) begin
      overlap <= '0;
    end else if (frame_tick) begin
      overlap <= OVL_W'(overlap_inc);
    end else if (overlap_inc && (overlap != OVL_MAX)) begin
      overlap <= overlap + 1'b1;
    end
  end

  // FSM register with lives, flash counter and collision pulse
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= RUN;
      lives_left <= LIVES_LOAD;
      flash_cnt  <= '0;
      collision  <= 1'b0;
    end else begin
      state      <= state_next;
      lives_left <= lives_next;
      flash_cnt  <= flash_next;
      collision  <= collision_next;
    end
  end

  // FSM next-state: frame-end collision check, invulnerability countdown, restart
  always_comb begin
    state_next     = state;
    lives_next     = lives_left;
    flash_next     = flash_cnt;
    collision_next = 1'b0;
    restart        = 1'b0;
    case (state)
      RUN: begin
        if (frame_tick && (overlap >= HIT_LIMIT)) begin
          collision_next = 1'b1;
          lives_next     = lives_left - 2'd1;
          if (lives_next == 2'd0) begin
            state_next = GAME_OVER;
          end else begin
            state_next = HIT;
            flash_next = FLASH_LOAD;
          end
        end
      end
      HIT: begin
        if (frame_tick) begin
          flash_next = flash_cnt - 1'b1;
          if (flash_next == '0) begin
            state_next = RUN;
          end
        end
      end
      GAME_OVER: begin
        if (key_rise) begin
          state_next = RUN;
          lives_next = LIVES_LOAD;
          flash_next = '0;
          restart    = 1'b1;
        end
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  assign game_over = (state == GAME_OVER);

  // Character blinks off during the invulnerability window
  assign char_en = char_visible && !((state == HIT) && flash_cnt[3]);

  // Layer priority: character over obstacle over background; inverted on game over
  always_comb begin
    pix = '0;
    if (vis_d) begin
      if (char_en) begin
        pix = {char_red, char_green, char_blue};
      end else if (obst_visible) begin
        pix = {obst_red, obst_green, obst_blue};
      end else begin
        pix = {bg_red, bg_green, bg_blue};
      end
      if (state == GAME_OVER) begin
        pix = ~pix;
      end
    end
  end

  // Output register for colour and syncs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vga_r  <= '0;
      vga_g  <= '0;
      vga_b  <= '0;
      vga_hs <= 1'b1;
      vga_vs <= 1'b1;
    end else begin
      vga_r  <= pix.r;
      vga_g  <= pix.g;
      vga_b  <= pix.b;
      vga_hs <= hs_d;
      vga_vs <= vs_d;
    end
  end

endmodule

// File: tb/tb_pixel_mixer.sv
// Directed bench for pixel_mixer with a frame-level behavioural reference model.
// Stimulus changes on falling edges; outputs are compared on falling edges.
// Runs to a single summary line.
module tb_pixel_mixer;

  localparam int SD   = 2;
  localparam int THR  = 8;
  localparam int LIV  = 3;
  localparam int FLSH = 60;

  localparam logic [11:0] CH = 12'h0F0;
  localparam logic [11:0] OB = 12'hF00;
  localparam logic [11:0] BG = 12'h00F;

  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] display_col;
  logic [10:0] display_row;
  logic        visible, hsync_in, vsync_in;
  logic [3:0]  char_red, char_green, char_blue;
  logic        char_visible;
  logic [3:0]  obst_red, obst_green, obst_blue;
  logic        obst_visible;
  logic [3:0]  bg_red, bg_green, bg_blue;
  logic        restart_key;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, collision, game_over;
  logic [1:0]  lives_left;

  int checks   = 0;
  int failures = 0;
  int coll_cnt = 0;
  bit started  = 1'b0;

  always #5 clock = ~clock;

  pixel_mixer #(
    .SYNC_DELAY(SD), .HIT_THRESHOLD(THR), .LIVES(LIV), .FLASH_FRAMES(FLSH)
  ) dut (
    .clock(clock), .reset(reset),
    .display_col(display_col), .display_row(display_row),
    .visible(visible), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .char_red(char_red), .char_green(char_green), .char_blue(char_blue),
    .char_visible(char_visible),
    .obst_red(obst_red), .obst_green(obst_green), .obst_blue(obst_blue),
    .obst_visible(obst_visible),
    .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue),
    .restart_key(restart_key),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs),
    .collision(collision), .game_over(game_over), .lives_left(lives_left)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int M_RUN = 0, M_HIT = 1, M_OVER = 2;

  logic [11:0] exp_rgb;
  logic        exp_hs, exp_vs, exp_coll, exp_over;
  logic [1:0]  exp_lives;

  initial begin : model
    bit vq[$], hq[$], vsq[$], kq[$];
    int mode, lives, flash, ovl;
    bit tick_seen;
    forever begin
      @(posedge clock or posedge reset);
      if (reset) begin
        vq = {}; hq = {}; vsq = {};
        for (int i = 0; i < SD; i++) begin
          vq.push_back(1'b0); hq.push_back(1'b1); vsq.push_back(1'b1);
        end
        kq = {1'b0, 1'b0, 1'b0};
        mode = M_RUN; lives = LIV; flash = 0; ovl = 0; tick_seen = 1'b0;
        exp_rgb = '0; exp_hs = 1'b1; exp_vs = 1'b1; exp_coll = 1'b0;
        exp_over = 1'b0; exp_lives = 2'(LIV);
      end else begin
        bit vd, rise, counts, blank;
        int pix, old_mode;
        // syncs and visible arrive SD samples late
        vd = vq.pop_front();     vq.push_back(visible);
        exp_hs = hq.pop_front(); hq.push_back(hsync_in);
        exp_vs = vsq.pop_front(); vsq.push_back(vsync_in);
        // colour of this pixel
        blank = (mode == M_HIT) && (((flash >> 3) & 1) == 1);
        if (!vd) pix = 0;
        else if (char_visible && !blank) pix = {char_red, char_green, char_blue};
        else if (obst_visible) pix = {obst_red, obst_green, obst_blue};
        else pix = {bg_red, bg_green, bg_blue};
        if (vd && mode == M_OVER) pix = pix ^ 12'hFFF;
        exp_rgb = 12'(pix);
        // button: level seen two samples ago is high, three samples ago low
        rise = kq[1] && !kq[0];
        kq.push_back(restart_key);
        void'(kq.pop_front());
        // game rules
        old_mode = mode;
        counts = (mode == M_RUN) && vd && char_visible && obst_visible;
        exp_coll = 1'b0;
        if (mode == M_RUN && tick_seen && ovl >= THR) begin
          exp_coll = 1'b1;
          lives--;
          if (lives == 0) mode = M_OVER;
          else begin mode = M_HIT; flash = FLSH; end
        end else if (mode == M_HIT && tick_seen) begin
          flash--;
          if (flash == 0) mode = M_RUN;
        end else if (mode == M_OVER && rise) begin
          mode = M_RUN; lives = LIV; flash = 0;
        end
        if (old_mode == M_OVER && rise) ovl = 0;
        else if (tick_seen) ovl = counts ? 1 : 0;
        else if (counts && ovl < 4095) ovl++;
        tick_seen = (display_col == 0) && (display_row == 0);
        exp_over = (mode == M_OVER);
        exp_lives = 2'(lives);
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  initial begin : compare
    forever begin
      @(negedge clock);
      if (collision === 1'b1) coll_cnt++;
      if (started) begin
        chk("cmp_rgb", {vga_r, vga_g, vga_b}, exp_rgb);
        chk("cmp_hs", vga_hs, exp_hs);
        chk("cmp_vs", vga_vs, exp_vs);
        chk("cmp_collision", collision, exp_coll);
        chk("cmp_game_over", game_over, exp_over);
        chk("cmp_lives", lives_left, exp_lives);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic px(input logic [11:0] col, input logic [10:0] row, input logic vis,
                    input logic cv, input logic ov);
    display_col = col; display_row = row; visible = vis;
    {char_red, char_green, char_blue} = CH; char_visible = cv;
    {obst_red, obst_green, obst_blue} = OB; obst_visible = ov;
    {bg_red, bg_green, bg_blue} = BG;
    @(negedge clock);
  endtask

  // One short frame: tick, settle, n overlap pixels, tail
  task automatic frame(input int n);
    px(12'd0, 11'd0, 1'b1, 1'b0, 1'b0);
    repeat (3) px(12'd1, 11'd1, 1'b1, 1'b0, 1'b0);
    repeat (n) px(12'd2, 11'd1, 1'b1, 1'b1, 1'b1);
    repeat (2) px(12'd3, 11'd1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic frames(input int k);
    for (int i = 0; i < k; i++) frame(0);
  endtask

  task automatic hold_chk(input string name, input logic vis, input logic cv,
                          input logic ov, input logic [11:0] exp);
    repeat (4) px(12'd5, 11'd5, vis, cv, ov);
    chk(name, {vga_r, vga_g, vga_b}, exp);
  endtask

  // ---------------- directed sequence ----------------
  initial begin : stim
    logic [7:0] pat;
    pat = 8'b1110_1001;
    reset = 1'b1; restart_key = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    display_col = 12'd5; display_row = 11'd5; visible = 1'b0;
    {char_red, char_green, char_blue} = '0; char_visible = 1'b0;
    {obst_red, obst_green, obst_blue} = '0; obst_visible = 1'b0;
    {bg_red, bg_green, bg_blue} = '0;
    repeat (2) @(negedge clock);
    chk("rst_rgb", {vga_r, vga_g, vga_b}, 12'h000);
    chk("rst_hs", vga_hs, 1'b1);
    chk("rst_vs", vga_vs, 1'b1);
    chk("rst_collision", collision, 1'b0);
    chk("rst_game_over", game_over, 1'b0);
    chk("rst_lives", lives_left, 2'd3);
    reset = 1'b0;
    started = 1'b1;

    // sync path: vga_hs repeats hsync_in three cycles later; colour stays 0 off-screen
    {char_red, char_green, char_blue} = CH; char_visible = 1'b1;
    for (int i = 0; i < 10; i++) begin
      hsync_in = (i < 8) ? pat[i] : 1'b1;
      vsync_in = (i < 8) ? pat[7-i] : 1'b1;
      @(negedge clock);
      if (i >= 2) chk("hs_pipe", vga_hs, pat[i-2]);
    end
    chk("blank_offscreen", {vga_r, vga_g, vga_b}, 12'h000);

    // layer priority
    hold_chk("prio_char", 1'b1, 1'b1, 1'b1, 12'h0F0);
    hold_chk("prio_obst", 1'b1, 1'b0, 1'b1, 12'hF00);
    hold_chk("prio_bg",   1'b1, 1'b0, 1'b0, 12'h00F);

    // 7 overlaps stay below threshold, 8 is a hit (reported at the following tick)
    frame(7);
    frame(8);
    chk("below_thr_coll", coll_cnt, 0);
    chk("below_thr_lives", lives_left, 2'd3);
    px(12'd0, 11'd0, 1'b1, 1'b0, 1'b0);
    chk("coll_early", collision, 1'b0);
    px(12'd1, 11'd1, 1'b1, 1'b0, 1'b0);
    chk("coll_pulse", collision, 1'b1);
    chk("coll_lives", lives_left, 2'd2);
    px(12'd1, 11'd1, 1'b1, 1'b0, 1'b0);
    chk("coll_once", collision, 1'b0);
    hold_chk("blink_blank", 1'b1, 1'b1, 1'b0, 12'h00F);

    // invulnerability: heavy overlap ignored, 59th-tick frame ignored, RUN after 60 ticks
    frame(500);
    frames(57);
    frame(8);
    frame(0);
    chk("hit_ignored_coll", coll_cnt, 1);
    chk("hit_ignored_lives", lives_left, 2'd2);
    hold_chk("run_char_shown", 1'b1, 1'b1, 1'b0, 12'h0F0);

    // second and third collisions lead to game over
    frame(8);
    frame(0);
    chk("second_coll", coll_cnt, 2);
    chk("second_lives", lives_left, 2'd1);
    frames(59);
    frame(8);
    frame(0);
    chk("third_coll", coll_cnt, 3);
    chk("over_lives", lives_left, 2'd0);
    chk("over_flag", game_over, 1'b1);
    hold_chk("over_invert", 1'b1, 1'b0, 1'b0, 12'hFF0);
    hold_chk("over_offscreen", 1'b0, 1'b0, 1'b0, 12'h000);

    // restart: game_over falls on the third edge after the key rises
    restart_key = 1'b1;
    @(negedge clock);
    @(negedge clock);
    chk("restart_wait", game_over, 1'b1);
    @(negedge clock);
    chk("restart_fall", game_over, 1'b0);
    chk("restart_lives", lives_left, 2'd3);
    repeat (2) @(negedge clock);
    restart_key = 1'b0;

    // enter HIT again, then reset in the middle of a line
    frame(8);
    frame(0);
    chk("fourth_coll", coll_cnt, 4);
    hsync_in = 1'b0; vsync_in = 1'b0;
    repeat (4) px(12'd7, 11'd3, 1'b1, 1'b0, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_rgb", {vga_r, vga_g, vga_b}, 12'h000);
    chk("midrst_hs", vga_hs, 1'b1);
    chk("midrst_vs", vga_vs, 1'b1);
    chk("midrst_lives", lives_left, 2'd3);
    chk("midrst_over", game_over, 1'b0);
    hsync_in = 1'b1; vsync_in = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    // back in RUN straight away: a qualifying frame hits at the next evaluation
    frame(8);
    frame(0);
    chk("postrst_coll", coll_cnt, 5);
    chk("postrst_lives", lives_left, 2'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #500000;
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
